// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: turns 'R'/'W' command frames from the UART receiver into single
//   Wishbone classic cycles and returns a status byte (plus read data on a good
//   read) to the UART transmitter.
// Latency: bus cycle starts the cycle after the last frame byte; the status byte
//   appears the cycle after the bus cycle ends; then one tx byte per accepted cycle.
// Backpressure: rx_ready is low from the last frame byte until the response has
//   drained; each tx byte is held until tx_valid && tx_ready.
// Ports: clk/rst (async, active-high); rx_* byte stream in with overflow and
//   frame_error pulses; tx_* byte stream out; wb_* 16-bit Wishbone master;
//   bad_cmd pulses for one cycle when an unknown command byte is discarded.
module uart_wb_bridge #(
  parameter logic [7:0] TIMEOUT = 8'hff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        rx_overflow,
  input  logic        rx_frame_error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [15:0] wb_addr,
  output logic [15:0] wb_data_write,
  input  logic [15:0] wb_data_read,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        bad_cmd
);

  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_ERR = 8'h01;
  localparam logic [7:0] ST_TMO = 8'h02;

  typedef enum logic [3:0] {
    S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO,
    S_BUS, S_RESP_STATUS, S_RESP_HI, S_RESP_LO
  } state_e;

  state_e      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_we_q, wb_we_d;
  logic [15:0] wb_addr_q, wb_addr_d;
  logic [15:0] wb_wdata_q, wb_wdata_d;
  logic        bad_cmd_q, bad_cmd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] rdata_q, rdata_d;

  // rx_ready_q is high only in receive states, so it also qualifies the
  // abort pulses: they are ignored while a bus cycle or response is running.
  logic rx_fire, rx_abort, cmd_ok, bus_done;
  assign rx_fire  = rx_valid && rx_ready_q;
  assign rx_abort = (rx_overflow || rx_frame_error) && rx_ready_q;
  assign cmd_ok   = (rx_data == CMD_RD) || (rx_data == CMD_WR);
  // Counter at 1 means this is the last cycle we wait for a response.
  assign bus_done = wb_ack || wb_err || (cnt_q <= 8'd1);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CMD;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      wb_cyc_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= 16'h0000;
      wb_wdata_q <= 16'h0000;
      bad_cmd_q  <= 1'b0;
      cnt_q      <= TIMEOUT;
      status_q   <= ST_OK;
      rdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wb_cyc_q   <= wb_cyc_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wb_wdata_q <= wb_wdata_d;
      bad_cmd_q  <= bad_cmd_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD:     if (!rx_abort && rx_fire && cmd_ok) state_d = S_ADDR_HI;
      S_ADDR_HI: if (rx_abort) state_d = S_CMD; else if (rx_fire) state_d = S_ADDR_LO;
      S_ADDR_LO: if (rx_abort) state_d = S_CMD;
                 else if (rx_fire) state_d = wb_we_q ? S_DATA_HI : S_BUS;
      S_DATA_HI: if (rx_abort) state_d = S_CMD; else if (rx_fire) state_d = S_DATA_LO;
      S_DATA_LO: if (rx_abort) state_d = S_CMD; else if (rx_fire) state_d = S_BUS;
      S_BUS:     if (bus_done) state_d = S_RESP_STATUS;
      S_RESP_STATUS:
        if (tx_ready) state_d = (status_q == ST_OK && !wb_we_q) ? S_RESP_HI : S_CMD;
      S_RESP_HI: if (tx_ready) state_d = S_RESP_LO;
      S_RESP_LO: if (tx_ready) state_d = S_CMD;
      default:   state_d = S_CMD;
    endcase
  end

  // Output / datapath next values (registered from the next state)
  always_comb begin
    rx_ready_d = state_d inside {S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO};
    tx_valid_d = state_d inside {S_RESP_STATUS, S_RESP_HI, S_RESP_LO};
    wb_cyc_d   = (state_d == S_BUS);
    wb_we_d    = wb_we_q;
    wb_addr_d  = wb_addr_q;
    wb_wdata_d = wb_wdata_q;
    bad_cmd_d  = 1'b0;
    cnt_d      = TIMEOUT;
    status_d   = status_q;
    rdata_d    = rdata_q;
    tx_data_d  = tx_data_q;

    // A byte arriving together with an abort pulse is dropped.
    if (rx_fire && !rx_abort) begin
      case (state_q)
        S_CMD:     if (cmd_ok) wb_we_d = (rx_data == CMD_WR); else bad_cmd_d = 1'b1;
        S_ADDR_HI: wb_addr_d[15:8]  = rx_data;
        S_ADDR_LO: wb_addr_d[7:0]   = rx_data;
        S_DATA_HI: wb_wdata_d[15:8] = rx_data;
        S_DATA_LO: wb_wdata_d[7:0]  = rx_data;
        default:   ;
      endcase
    end

    // Err wins over ack; a response on the final counted cycle still counts.
    if (state_q == S_BUS) begin
      cnt_d = cnt_q - 8'd1;
      if (wb_err) begin
        status_d = ST_ERR;
      end else if (wb_ack) begin
        status_d = ST_OK;
        rdata_d  = wb_data_read;
      end else if (cnt_q <= 8'd1) begin
        status_d = ST_TMO;
      end
    end

    case (state_d)
      S_RESP_STATUS: tx_data_d = status_d;
      S_RESP_HI:     tx_data_d = rdata_q[15:8];
      S_RESP_LO:     tx_data_d = rdata_q[7:0];
      default:       ;
    endcase
  end

  assign rx_ready      = rx_ready_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign wb_cyc        = wb_cyc_q;
  assign wb_stb        = wb_cyc_q;
  assign wb_we         = wb_we_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data_write = wb_wdata_q;
  assign bad_cmd       = bad_cmd_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: self-checking bench for uart_wb_bridge.
// Table of directed frames, hand-written corner sequences, then random frames
// checked against a frame-level reference model.
module tb_uart_wb_bridge;

  localparam logic [7:0] TMO = 8'd4;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, rx_overflow, rx_frame_error;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_addr, wb_data_write, wb_data_read;
  logic        wb_ack, wb_err, bad_cmd;

  uart_wb_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .rx_frame_error(rx_frame_error),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data_write(wb_data_write), .wb_data_read(wb_data_read),
    .wb_ack(wb_ack), .wb_err(wb_err), .bad_cmd(bad_cmd)
  );

  int tests_run = 0;
  int tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter
  int cyc_no = 0;
  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  // Wishbone slave: responds on the slv_delay-th cycle of a bus cycle.
  // slv_mode: 0 ack, 1 err, 2 never respond, 3 ack+err together.
  int          slv_mode = 0, slv_delay = 1;
  logic [15:0] slv_rdata = 16'h0000;
  int          cyc_len = 0, last_len = 0, last_cyc_at = 0, bus_count = 0, stab_viol = 0;
  logic [15:0] b_addr = 16'h0, b_wdata = 16'h0;
  logic        b_we = 1'b0;
  initial begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_data_read = 16'h0000;
    forever begin
      @(posedge clk); #1;
      wb_ack = 1'b0; wb_err = 1'b0;
      if (wb_cyc && wb_stb) begin
        cyc_len++;
        if (cyc_len == 1) begin
          bus_count++; b_addr = wb_addr; b_we = wb_we; b_wdata = wb_data_write;
        end else if (wb_addr !== b_addr || wb_we !== b_we || wb_data_write !== b_wdata) begin
          stab_viol++;
        end
        last_len = cyc_len;
        last_cyc_at = cyc_no;
        if (cyc_len == slv_delay) begin
          wb_data_read = slv_rdata;
          case (slv_mode)
            0: wb_ack = 1'b1;
            1: wb_err = 1'b1;
            3: begin wb_ack = 1'b1; wb_err = 1'b1; end
            default: ;
          endcase
        end
      end else begin
        cyc_len = 0;
      end
    end
  end

  // tx_ready driver
  bit   tx_rand = 1'b0;
  logic tx_force = 1'b1;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : tx_force;
    end
  end

  // tx monitor and running protocol checks
  logic [7:0] txq[$];
  int         tx_at[$];
  int         bad_pulses = 0, hold_viol = 0, overlap_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_tx = 8'h00;
  initial forever begin
    @(negedge clk);
    if (tx_valid && prev_stall && tx_data !== prev_tx) hold_viol++;
    if (tx_valid && rx_ready) overlap_viol++;
    if (bad_cmd) bad_pulses++;
    if (tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      tx_at.push_back(cyc_no);
    end
    prev_stall = tx_valid && !tx_ready;
    prev_tx = tx_data;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic ovf, input logic ferr);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; rx_overflow = ovf; rx_frame_error = ferr;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_overflow = 1'b0; rx_frame_error = 1'b0;
        return;
      end
    end
    check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    rx_valid = 1'b0; rx_overflow = 1'b0; rx_frame_error = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_ready && !tx_valid) break;
    end
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // Send one frame, let it complete, then compare the bus transfer and response.
  task automatic do_frame(input string tag, input logic is_wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata,
                          input int mode, input int delay, input int exp_n,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input int exp_len, input bit timing);
    int bc0;
    logic [7:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    bc0 = bus_count;
    slv_mode = mode; slv_delay = delay; slv_rdata = rdata;
    txq.delete(); tx_at.delete();
    send_byte(is_wr ? 8'h57 : 8'h52, 1'b0, 1'b0);
    send_byte(addr[15:8], 1'b0, 1'b0);
    send_byte(addr[7:0], 1'b0, 1'b0);
    if (is_wr) begin
      send_byte(wdata[15:8], 1'b0, 1'b0);
      send_byte(wdata[7:0], 1'b0, 1'b0);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check({tag, "_bus_count"}, bus_count - bc0, 32'd1);
    check({tag, "_we"}, 32'(b_we), 32'(is_wr));
    check({tag, "_addr"}, 32'(b_addr), 32'(addr));
    if (is_wr) check({tag, "_wdata"}, 32'(b_wdata), 32'(wdata));
    check({tag, "_cyc_len"}, last_len, exp_len);
    check({tag, "_ntx"}, txq.size(), exp_n);
    if (txq.size() == exp_n) begin
      for (int k = 0; k < exp_n; k++) check({tag, "_txbyte"}, 32'(txq[k]), 32'(e[k]));
      if (timing) begin
        check({tag, "_status_latency"}, tx_at[0], last_cyc_at + 1);
        for (int k = 1; k < exp_n; k++) check({tag, "_tx_consecutive"}, tx_at[k], tx_at[k-1] + 1);
      end
    end
  endtask

  // Reference model: response expected for one frame from the bus outcome.
  function automatic void model(input logic is_wr, input int mode, input int delay,
                                input logic [15:0] rdata, output int n,
                                output logic [7:0] e0, output logic [7:0] e1,
                                output logic [7:0] e2, output int len);
    bit answered;
    answered = (mode != 2) && (delay <= int'(TMO));
    if (!answered)      e0 = 8'h02;
    else if (mode == 0) e0 = 8'h00;
    else                e0 = 8'h01;
    e1 = rdata[15:8];
    e2 = rdata[7:0];
    n = (e0 == 8'h00 && !is_wr) ? 3 : 1;
    len = answered ? delay : int'(TMO);
  endfunction

  typedef struct {
    string       name;
    logic        is_wr;
    logic [15:0] addr, wdata, rdata;
    int          mode, delay, exp_n;
    logic [7:0]  e0, e1, e2;
    int          exp_len;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int bp0, bc0, bp_bad, n, len, mode, delay, kind;
    logic [7:0] e0, e1, e2, b;
    logic is_wr;
    logic [15:0] addr, wdata, rdata;

    vecs[0] = '{"wr_ack",     1'b1, 16'h0010, 16'hABCD, 16'h0000, 0, 3, 1, 8'h00, 8'h00, 8'h00, 3};
    vecs[1] = '{"rd_ack",     1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0, 1, 3, 8'h00, 8'hBE, 8'hEF, 1};
    vecs[2] = '{"rd_err",     1'b0, 16'h0042, 16'h0000, 16'h1111, 1, 2, 1, 8'h01, 8'h00, 8'h00, 2};
    vecs[3] = '{"rd_tmo",     1'b0, 16'h0043, 16'h0000, 16'h2222, 2, 1, 1, 8'h02, 8'h00, 8'h00, 4};
    vecs[4] = '{"rd_both",    1'b0, 16'h0044, 16'h0000, 16'h3333, 3, 1, 1, 8'h01, 8'h00, 8'h00, 1};
    vecs[5] = '{"wr_err",     1'b1, 16'h8001, 16'h5A5A, 16'h0000, 1, 1, 1, 8'h01, 8'h00, 8'h00, 1};
    vecs[6] = '{"wr_tmo",     1'b1, 16'hFFFF, 16'h0000, 16'h0000, 2, 1, 1, 8'h02, 8'h00, 8'h00, 4};
    vecs[7] = '{"rd_ack_last",1'b0, 16'h0045, 16'h0000, 16'h0F0F, 0, 4, 3, 8'h00, 8'h0F, 8'h0F, 4};
    vecs[8] = '{"rd_ack_late",1'b0, 16'h00FF, 16'h0000, 16'h4444, 0, 5, 1, 8'h02, 8'h00, 8'h00, 4};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_overflow = 1'b0; rx_frame_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_wb_cyc", 32'(wb_cyc), 32'd0);
    check("rst_wb_stb", 32'(wb_stb), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_bad_cmd", 32'(bad_cmd), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_wdata", 32'(wb_data_write), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 9; i++)
      do_frame(vecs[i].name, vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
               vecs[i].mode, vecs[i].delay, vecs[i].exp_n, vecs[i].e0, vecs[i].e1,
               vecs[i].e2, vecs[i].exp_len, 1'b1);

    // Resync: unknown command, aborted frames, then a normal read
    bp0 = bad_pulses; bc0 = bus_count; txq.delete();
    send_byte(8'h41, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("resync_bad_pulse", bad_pulses - bp0, 32'd1);
    check("resync_rx_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h57, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    send_byte(8'h52, 1'b0, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("abort_no_bus", bus_count - bc0, 32'd0);
    check("abort_no_tx", txq.size(), 32'd0);
    check("abort_rx_ready", 32'(rx_ready), 32'd1);
    check("abort_no_bad_cmd", bad_pulses - bp0, 32'd1);
    do_frame("resync_rd", 1'b0, 16'h0001, 16'h0000, 16'h7E57, 0, 1, 3,
             8'h00, 8'h7E, 8'h57, 1, 1'b1);

    // Back-pressure on the read response
    tx_force = 1'b0; txq.delete();
    slv_mode = 0; slv_delay = 2; slv_rdata = 16'hC0DE;
    send_byte(8'h52, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid) break;
    end
    check("bp_tx_valid", 32'(tx_valid), 32'd1);
    bp_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== 8'h00 || rx_ready) bp_bad++;
    end
    check("bp_hold", bp_bad, 32'd0);
    tx_force = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("bp_ntx", txq.size(), 32'd3);
    if (txq.size() == 3) begin
      check("bp_byte0", 32'(txq[0]), 32'h00);
      check("bp_byte1", 32'(txq[1]), 32'hC0);
      check("bp_byte2", 32'(txq[2]), 32'hDE);
    end

    // Reset in the middle of a bus cycle
    slv_mode = 2; txq.delete();
    send_byte(8'h52, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_cyc) break;
    end
    check("midbus_cyc_seen", 32'(wb_cyc), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_cyc", 32'(wb_cyc), 32'd0);
    check("rst_async_stb", 32'(wb_stb), 32'd0);
    check("rst_async_tx_valid", 32'(tx_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_rx_ready", 32'(rx_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("rst_no_tx", txq.size(), 32'd0);
    do_frame("post_rst_wr", 1'b1, 16'h0100, 16'h1234, 16'h0000, 0, 2, 1,
             8'h00, 8'h00, 8'h00, 2, 1'b1);

    // Random frames with random tx back-pressure
    tx_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h52 || b == 8'h57) b = 8'h00;
        bp0 = bad_pulses; bc0 = bus_count;
        send_byte(b, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rand_bad_pulse", bad_pulses - bp0, 32'd1);
        check("rand_bad_no_bus", bus_count - bc0, 32'd0);
      end else begin
        is_wr = 1'($urandom_range(0, 1));
        addr  = 16'($urandom);
        wdata = 16'($urandom);
        rdata = 16'($urandom);
        mode  = $urandom_range(0, 3);
        delay = $urandom_range(1, 6);
        model(is_wr, mode, delay, rdata, n, e0, e1, e2, len);
        do_frame("rand", is_wr, addr, wdata, rdata, mode, delay, n, e0, e1, e2, len, 1'b0);
      end
    end
    tx_rand = 1'b0;

    check("tx_hold_stable", hold_viol, 32'd0);
    check("rx_ready_during_tx", overlap_viol, 32'd0);
    check("bus_fields_stable", stab_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
